floo_test_harness: RTL and testbench

Self-contained FlooNoC test harness used as the top of binary-run simulation. It runs a deterministic write-then-read-back traffic pattern from an on-board initiator, across a registered NoC link, to an on-board memory endpoint. It publishes a fesvr-style `tohost` status word that the enclosing bench polls to decide pass or fail. Its only external pins are clock and reset; all observability is through hierarchical references.

---
 rtl/floo_tb_pkg.sv | 30 +++
 rtl/floo_link_reg.sv | 34 +++
 rtl/floo_test_harness.sv | 156 +++++++++++++++
 tb/tb_floo_test_harness.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/floo_tb_pkg.sv
// Shared constants, state encoding and traffic pattern for the FlooNoC
// binary-run harness.
package floo_tb_pkg;

  localparam int unsigned NumReqDefault    = 256;
  localparam int unsigned AddrWidthDefault = 16;
  localparam int unsigned DataWidthDefault = 64;
  localparam int unsigned MemDepthDefault  = 1024;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WRITE   = 3'd1;
  localparam logic [2:0] ST_DRAIN_W = 3'd2;
  localparam logic [2:0] ST_READ    = 3'd3;
  localparam logic [2:0] ST_DRAIN_R = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_WRITE   = ST_WRITE,
    S_DRAIN_W = ST_DRAIN_W,
    S_READ    = ST_READ,
    S_DRAIN_R = ST_DRAIN_R,
    S_DONE    = ST_DONE
  } state_e;

  function automatic logic [63:0] pattern(input logic [31:0] i);
    return {i ^ 32'hA5A5_5A5A, ~i};
  endfunction

endpackage

// File: rtl/floo_link_reg.sv
// Full-throughput valid/ready register slice for one NoC link direction.
module floo_link_reg #(
  parameter type T = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic valid_i,
  output logic ready_o,
  input  T     data_i,
  output logic valid_o,
  input  logic ready_i,
  output T     data_o
);

  logic valid_q;
  T     data_q;

  // Accepts a new beat in the same cycle the held one drains.
  assign ready_o = !valid_q || ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (ready_o) begin
      valid_q <= valid_i;
      if (valid_i) data_q <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/floo_test_harness.sv
// Write-then-read-back traffic generator, registered NoC link and memory
// endpoint; publishes a fesvr-style tohost word for the enclosing bench.
module floo_test_harness
  import floo_tb_pkg::*;
#(
  parameter int unsigned NumReq          = NumReqDefault,
  parameter int unsigned AddrWidth       = AddrWidthDefault,
  parameter int unsigned DataWidth       = DataWidthDefault,
  parameter int unsigned MemDepth        = MemDepthDefault,
  parameter bit          InjectFault     = 1'b0,
  parameter int unsigned FaultAddr       = 5,
  parameter bit          StallEveryOther = 1'b0
) (
  input logic clk_i,
  input logic rst_ni
);

  localparam int unsigned MemIdxW = (MemDepth > 1) ? $clog2(MemDepth) : 1;
  localparam logic [MemIdxW-1:0] FaultIdx = MemIdxW'(FaultAddr % MemDepth);

  typedef struct packed {
    logic                 write;
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] data;
  } req_t;

  typedef struct packed {
    logic                 write;
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] data;
  } rsp_t;

  function automatic logic [DataWidth-1:0] pat_w(input logic [31:0] i);
    return DataWidth'(pattern(i));
  endfunction

  state_e      state_q, state_d;
  logic [31:0] issue_cnt_q, rsp_cnt_q, err_cnt_q, err_cnt_d;
  logic        done_q;
  logic [63:0] tohost_q;

  req_t ini_req, ep_req;
  rsp_t ep_rsp_q, ini_rsp;
  logic ini_req_valid, ini_req_ready;
  logic ep_req_valid, ep_req_ready;
  logic ep_rsp_valid_q, ep_rsp_ready;
  logic ini_rsp_valid;
  logic req_hs, last_issue, rsp_done, mismatch;
  logic stall_q, ep_accept, fault_hit;
  logic [MemIdxW-1:0]   mem_idx;
  logic [DataWidth-1:0] mem_q [MemDepth];

  // Initiator
  assign ini_req_valid = (state_q == S_WRITE) || (state_q == S_READ);

  always_comb begin
    ini_req       = '0;
    ini_req.write = (state_q == S_WRITE);
    ini_req.addr  = AddrWidth'(issue_cnt_q);
    ini_req.data  = (state_q == S_WRITE) ? pat_w(issue_cnt_q) : '0;
  end

  assign req_hs     = ini_req_valid && ini_req_ready;
  assign last_issue = (issue_cnt_q == NumReq - 1);
  // Drain completes on the cycle the final outstanding response arrives.
  assign rsp_done   = ini_rsp_valid ? (rsp_cnt_q == NumReq - 1) : (rsp_cnt_q == NumReq);
  assign mismatch   = ini_rsp_valid && !ini_rsp.write &&
                      (ini_rsp.data != pat_w(32'(ini_rsp.addr)));
  assign err_cnt_d  = (mismatch && (err_cnt_q != '1)) ? err_cnt_q + 32'd1 : err_cnt_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    state_d = S_WRITE;
      S_WRITE:   if (req_hs && last_issue) state_d = S_DRAIN_W;
      S_DRAIN_W: if (rsp_done) state_d = S_READ;
      S_READ:    if (req_hs && last_issue) state_d = S_DRAIN_R;
      S_DRAIN_R: if (rsp_done) state_d = S_DONE;
      S_DONE:    state_d = S_DONE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      issue_cnt_q <= '0;
      rsp_cnt_q   <= '0;
      err_cnt_q   <= '0;
      done_q      <= 1'b0;
      tohost_q    <= '0;
    end else begin
      state_q   <= state_d;
      err_cnt_q <= err_cnt_d;
      if (req_hs) issue_cnt_q <= last_issue ? '0 : issue_cnt_q + 32'd1;
      if ((state_q == S_DRAIN_W) && rsp_done) rsp_cnt_q <= '0;
      else if (ini_rsp_valid)                 rsp_cnt_q <= rsp_cnt_q + 32'd1;
      if ((state_q == S_DRAIN_R) && rsp_done) begin
        done_q   <= 1'b1;
        tohost_q <= {31'b0, err_cnt_d, 1'b1};
      end
    end
  end

  floo_link_reg #(.T(req_t)) i_req_reg (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (ini_req_valid),
    .ready_o (ini_req_ready),
    .data_i  (ini_req),
    .valid_o (ep_req_valid),
    .ready_i (ep_req_ready),
    .data_o  (ep_req)
  );

  // Memory endpoint
  assign ep_req_ready = (!ep_rsp_valid_q || ep_rsp_ready) && !(StallEveryOther && stall_q);
  assign ep_accept    = ep_req_valid && ep_req_ready;
  assign mem_idx      = MemIdxW'(32'(ep_req.addr) % MemDepth);
  assign fault_hit    = InjectFault && (state_q == S_DRAIN_W) && rsp_done;

  always_ff @(posedge clk_i) begin
    if (ep_accept && ep_req.write) mem_q[mem_idx] <= ep_req.data;
    if (fault_hit) mem_q[FaultIdx] <= '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ep_rsp_valid_q <= 1'b0;
      ep_rsp_q       <= '0;
      stall_q        <= 1'b0;
    end else begin
      stall_q <= !stall_q;
      if (ep_accept) begin
        ep_rsp_valid_q <= 1'b1;
        ep_rsp_q.write <= ep_req.write;
        ep_rsp_q.addr  <= ep_req.addr;
        ep_rsp_q.data  <= ep_req.write ? '0 : mem_q[mem_idx];
      end else if (ep_rsp_ready) begin
        ep_rsp_valid_q <= 1'b0;
      end
    end
  end

  floo_link_reg #(.T(rsp_t)) i_rsp_reg (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (ep_rsp_valid_q),
    .ready_o (ep_rsp_ready),
    .data_i  (ep_rsp_q),
    .valid_o (ini_rsp_valid),
    .ready_i (1'b1),
    .data_o  (ini_rsp)
  );

endmodule

// File: tb/tb_floo_test_harness.sv
// Five harness configurations (clean, fault, stalled, single request, address
// wrap) checked every cycle against a memory/queue model of the traffic.
module tb_floo_test_harness;

  logic       clk;
  logic [4:0] rst_n;

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;

  function automatic int unsigned cfg_nreq(input int g);
    case (g)
      3:       return 1;
      4:       return 20;
      default: return 256;
    endcase
  endfunction

  function automatic int unsigned cfg_depth(input int g);
    return (g == 4) ? 16 : 1024;
  endfunction

  function automatic logic [63:0] pat(input int unsigned i);
    logic [31:0] v;
    v = i;
    return {v ^ 32'hA5A5_5A5A, ~v};
  endfunction

  logic [4:0]  pv, pr, pw, rv, rw, ev, er, dn;
  logic [15:0] pa [5];
  logic [15:0] ra [5];
  logic [63:0] pd [5];
  logic [63:0] rd [5];
  logic [80:0] ed [5];
  logic [63:0] th [5];
  logic [31:0] ec [5];

  for (genvar g = 0; g < 5; g++) begin : g_dut
    floo_test_harness #(
      .NumReq          (cfg_nreq(g)),
      .MemDepth        (cfg_depth(g)),
      .InjectFault     (g == 1),
      .FaultAddr       (5),
      .StallEveryOther (g == 2)
    ) u_dut (
      .clk_i  (clk),
      .rst_ni (rst_n[g])
    );
    assign pv[g] = u_dut.ini_req_valid;
    assign pr[g] = u_dut.ini_req_ready;
    assign pw[g] = u_dut.ini_req.write;
    assign pa[g] = u_dut.ini_req.addr;
    assign pd[g] = u_dut.ini_req.data;
    assign rv[g] = u_dut.ini_rsp_valid;
    assign rw[g] = u_dut.ini_rsp.write;
    assign ra[g] = u_dut.ini_rsp.addr;
    assign rd[g] = u_dut.ini_rsp.data;
    assign ev[g] = u_dut.ep_req_valid;
    assign er[g] = u_dut.ep_req_ready;
    assign ed[g] = u_dut.ep_req;
    assign th[g] = u_dut.tohost_q;
    assign ec[g] = u_dut.err_cnt_q;
    assign dn[g] = u_dut.done_q;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int k, input logic [127:0] act,
                     input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, k, act, exp);
    end
  endtask

  // Traffic model: memory array plus in-order queue of expected responses
  logic [63:0]  mmem [5][1024];
  logic [80:0]  ring [5][8];
  int unsigned  head [5], tail [5];
  int unsigned  m_nreq [5], m_nrsp [5], m_err [5], cyc [5], done_at [5];
  logic         prev_stall [5];
  logic [80:0]  prev_ed [5];

  always @(negedge clk) begin
    for (int k = 0; k < 5; k++) begin
      if (!rst_n[k]) begin
        m_nreq[k] = 0; m_nrsp[k] = 0; m_err[k] = 0; cyc[k] = 0; done_at[k] = 0;
        head[k] = 0; tail[k] = 0; prev_stall[k] = 1'b0;
        chk("rst_tohost", k, th[k], 0);
        chk("rst_done", k, dn[k], 0);
        chk("rst_err", k, ec[k], 0);
      end else begin
        int unsigned n, d, a_exp;
        logic        w_exp, exp_done;
        logic [63:0] d_exp;
        logic [80:0] e;
        n = cfg_nreq(k);
        d = cfg_depth(k);
        cyc[k]++;
        exp_done = (m_nrsp[k] == 2 * n);
        chk("done", k, dn[k], exp_done);
        chk("tohost", k, th[k], exp_done ? {31'b0, m_err[k], 1'b1} : 64'h0);
        chk("err_cnt", k, ec[k], m_err[k]);
        if (dn[k] && done_at[k] == 0) done_at[k] = cyc[k];

        if (pv[k] && pr[k]) begin
          if (m_nreq[k] >= 2 * n) begin
            chk("extra_req", k, m_nreq[k], 2 * n - 1);
          end else begin
            w_exp = (m_nreq[k] < n);
            a_exp = m_nreq[k] % n;
            d_exp = w_exp ? pat(a_exp) : 64'h0;
            chk("req", k, {pw[k], pa[k], pw[k] ? pd[k] : 64'h0}, {w_exp, 16'(a_exp), d_exp});
            if (!w_exp && m_nreq[k] == n && k == 1) mmem[k][5 % d] = 64'h0;
            if (w_exp) begin
              mmem[k][a_exp % d] = d_exp;
              e = {1'b1, 16'(a_exp), 64'h0};
            end else begin
              e = {1'b0, 16'(a_exp), mmem[k][a_exp % d]};
            end
            if (tail[k] - head[k] >= 8) chk("outstanding", k, tail[k] - head[k], 7);
            ring[k][tail[k] % 8] = e;
            tail[k]++;
            m_nreq[k]++;
          end
        end

        if (rv[k]) begin
          if (head[k] == tail[k]) begin
            chk("unexpected_rsp", k, {rw[k], ra[k]}, 0);
          end else begin
            e = ring[k][head[k] % 8];
            head[k]++;
            chk("rsp", k, {rw[k], ra[k], rw[k] ? 64'h0 : rd[k]}, e);
            if (!e[80] && e[63:0] != pat(e[79:64])) m_err[k]++;
            m_nrsp[k]++;
          end
        end

        if (prev_stall[k]) chk("stall_hold", k, {ev[k], ed[k]}, {1'b1, prev_ed[k]});
        prev_stall[k] = ev[k] && !er[k];
        prev_ed[k]    = ed[k];
      end
    end
  end

  task automatic wait_done(input logic [4:0] mask, input int budget);
    int c;
    c = 0;
    while (((dn & mask) != mask) && c < budget) begin
      @(negedge clk);
      c++;
    end
    #1;
    for (int k = 0; k < 5; k++)
      if (mask[k] && !dn[k]) chk("timeout_done", k, dn[k], 1);
  endtask

  initial begin
    rst_n = '0;
    repeat (5) @(negedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("reset_tohost", k, th[k], 64'h0);
      chk("reset_done", k, dn[k], 0);
    end
    @(negedge clk);
    #2 rst_n = '1;
    wait_done(5'b11111, 4000);

    chk("clean_tohost", 0, th[0], 64'h1);
    chk("clean_err", 0, ec[0], 0);
    chk("clean_cycles", 0, done_at[0], 519);
    chk("fault_err", 1, ec[1], 1);
    chk("fault_tohost", 1, th[1], 64'h3);
    chk("fault_cycles", 1, done_at[1], 519);
    chk("stall_tohost", 2, th[2], 64'h1);
    chk("stall_slower", 2, (done_at[2] > 519) && (done_at[2] < 2500), 1);
    chk("one_tohost", 3, th[3], 64'h1);
    chk("one_cycles", 3, done_at[3], 9);
    chk("wrap_err", 4, ec[4], 4);
    chk("wrap_tohost", 4, th[4], 64'h9);
    chk("wrap_cycles", 4, done_at[4], 47);

    // Double reset pulse on the default instance
    @(negedge clk);
    #2 rst_n[0] = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    chk("dbl_rst1_tohost", 0, th[0], 64'h0);
    chk("dbl_rst1_err", 0, ec[0], 0);
    #1 rst_n[0] = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    chk("dbl_mid_done", 0, dn[0], 0);
    #1 rst_n[0] = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    chk("dbl_rst2_tohost", 0, th[0], 64'h0);
    chk("dbl_rst2_done", 0, dn[0], 0);
    @(negedge clk);
    #2 rst_n[0] = 1'b1;
    wait_done(5'b00001, 1000);
    chk("dbl_final_tohost", 0, th[0], 64'h1);
    chk("dbl_final_err", 0, ec[0], 0);
    chk("dbl_final_cycles", 0, done_at[0], 519);

    repeat (3) @(negedge clk);
    #1;
    chk("tohost_stable", 0, th[0], 64'h1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
